hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Producer-side companion to the EX-stage forwarding unit in the 5-stage RISC-V pipeline. It tracks destination registers of in-flight long-latency producers (loads, multi-cycle mul/div), whose results forwarding cannot yet supply. It generates the ID-stage stall, the ID/EX bubble and the branch-redirect flushes. It also serialises fences and keeps saturating stall/flush performance counters.

## Interface
- CNT_W, 16, width of each performance counter
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a valid instruction
- id_rs1, id_rs2  in  5  ID source registers
- id_use_rs1, id_use_rs2  in  1  corresponding source is actually read
- id_rd  in  5  ID destination register
- id_regwrite  in  1  ID instruction writes id_rd
- id_long  in  1  ID instruction is a load or mul/div (long latency)
- id_fence  in  1  ID instruction is a fence
- done_valid  in  1  a long-latency result becomes forwardable this cycle
- done_rd  in  5  register of that result
- ex_redirect  in  1  EX resolved taken branch/jump mispredict
- stall_if  out  1  hold PC and IF/ID
- bubble_idex  out  1  insert NOP into ID/EX
- flush_ifid  out  1  clear IF/ID
- busy  out  32  scoreboard; bit 0 always 0
- stall_cnt, flush_cnt  out  CNT_W  saturating counters
- state  out  1  0=RUN, 1=DRAIN

## Operation
- Reset: busy=0, state=RUN, both counters 0. Combinational outputs follow the rules below from reset state: stall_if=0, flush_ifid=ex_redirect, bubble_idex=ex_redirect.
- hit(r) = busy[r] & ~(done_valid & done_rd==r & r!=0).
- dep_stall = id_valid & ((id_use_rs1 & hit(id_rs1)) | (id_use_rs2 & hit(id_rs2))).
- fence_stall = id_valid & id_fence & (busy != 0, after masking this cycle's done_rd clear).
- stall = (dep_stall | fence_stall) & ~ex_redirect.
- stall_if = stall. bubble_idex = stall | ex_redirect. flush_ifid = ex_redirect.
- issue = id_valid & ~stall & ~ex_redirect.
- Busy update at each edge:
  - clear: done_valid & done_rd!=0 clears busy[done_rd].
  - set: issue & id_regwrite & id_long & id_rd!=0 sets busy[id_rd].
  - If set and clear target the same register, set wins.
  - Register x0 is never set.
- FSM:
  - RUN -> DRAIN when fence_stall & ~ex_redirect.
  - DRAIN -> RUN when fence_stall deasserts or ex_redirect=1.
  - The state is observational only; stalling is driven by the equations above.
- Counters:
  - stall_cnt += 1 per cycle with stall=1.
  - flush_cnt += 1 per cycle with ex_redirect=1.
  - Both saturate at all-ones and never wrap.
- done_valid for a register that is not busy is harmless and leaves busy unchanged.

## Timing
- All stall, bubble and flush outputs are combinational from registered busy plus the current inputs, with 0-cycle latency.
- busy, state and the counters update at the rising edge of clk.
- A long op issued in cycle t has its busy bit visible from cycle t+1.
- A dependent instruction in ID stalls until the cycle in which done_valid names that register. It issues in that same cycle, and forwarding supplies the value.
- ex_redirect has priority over any stall in the same cycle: no stall, ID/EX bubbled, IF/ID flushed, no issue, no busy set.
- Reset asserted mid-operation immediately clears busy, state and the counters asynchronously. Outputs follow the reset state in the same cycle.

## Test plan
- Load-use:
  - Stimulus: issue lw x5 (id_long=1, id_rd=5). Next cycle, ID add with rs1=5 and use_rs1=1.
  - Response: stall_if=1 and bubble_idex=1 until done_valid with done_rd=5. In that cycle stall=0 and the add issues. busy[5]=0 afterwards.
- x0 handling:
  - Stimulus: lw with rd=0 issued, then a consumer of x0.
  - Response: busy stays 0 and no stall. done_rd=0 leaves busy unchanged.
- Redirect priority:
  - Stimulus: dep_stall condition present and ex_redirect=1 in the same cycle.
  - Response: stall_if=0, bubble_idex=1, flush_ifid=1, flush_cnt+1, stall_cnt unchanged, no busy set.
- Same-edge set and clear:
  - Stimulus: busy[7]=1; done_valid with done_rd=7 while a new div with rd=7 issues in the same cycle.
  - Response: busy[7]=1 after the edge.
- Fence drain:
  - Stimulus: busy={x3,x9}, fence in ID.
  - Response: state=DRAIN and stall held. Completing x3 keeps the stall. Completing x9 drops the stall that same cycle and state returns to RUN on the next edge.
- Saturation and async reset:
  - Stimulus: force 2^CNT_W+3 stall cycles, then assert rst mid-cycle.
  - Response: stall_cnt holds 0xFFFF (CNT_W=16). After rst, busy=0, counters=0 and state=RUN without waiting for a clock edge.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight long-latency destinations and derives ID stall, ID/EX bubble and
// IF/ID flush, serialises fences and keeps saturating stall/flush counters.
module hazard_scoreboard #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_regwrite,
  input  logic             id_long,
  input  logic             id_fence,
  input  logic             done_valid,
  input  logic [4:0]       done_rd,
  input  logic             ex_redirect,
  output logic             stall_if,
  output logic             bubble_idex,
  output logic             flush_ifid,
  output logic [31:0]      busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             state
);

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] busy_q;
  logic [31:0] busy_d;
  logic [31:0] clr_mask;
  logic [31:0] set_mask;
  logic [31:0] busy_eff;
  logic        dep_stall;
  logic        fence_stall;
  logic        stall;
  logic        issue;

  // A completion this cycle is already forwardable, so it is masked out before hazard checks.
  assign clr_mask = (done_valid && done_rd != 5'd0) ? (32'd1 << done_rd) : 32'd0;
  assign busy_eff = busy_q & ~clr_mask;

  assign dep_stall   = id_valid & ((id_use_rs1 & busy_eff[id_rs1]) |
                                   (id_use_rs2 & busy_eff[id_rs2]));
  assign fence_stall = id_valid & id_fence & (|busy_eff);
  assign stall       = (dep_stall | fence_stall) & ~ex_redirect;
  assign issue       = id_valid & ~stall & ~ex_redirect;

  assign stall_if    = stall;
  assign bubble_idex = stall | ex_redirect;
  assign flush_ifid  = ex_redirect;

  // Set is OR-ed after the clear so a same-edge reissue of the register wins.
  assign set_mask = (issue && id_regwrite && id_long && id_rd != 5'd0) ? (32'd1 << id_rd) : 32'd0;
  assign busy_d   = ((busy_q & ~clr_mask) | set_mask) & ~32'd1;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (fence_stall && !ex_redirect) state_d = DRAIN;
      DRAIN:   if (!fence_stall || ex_redirect) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q    <= 32'd0;
      state_q   <= RUN;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      busy_q  <= busy_d;
      state_q <= state_d;
      if (stall && stall_cnt != {CNT_W{1'b1}}) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (ex_redirect && flush_cnt != {CNT_W{1'b1}}) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

  assign busy  = busy_q;
  assign state = state_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_hazard_scoreboard;

  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             id_valid;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [4:0]       id_rd;
  logic             id_regwrite;
  logic             id_long;
  logic             id_fence;
  logic             done_valid;
  logic [4:0]       done_rd;
  logic             ex_redirect;
  logic             stall_if;
  logic             bubble_idex;
  logic             flush_ifid;
  logic [31:0]      busy;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             state;

  typedef struct {
    string            name;
    logic             stall_if;
    logic             bubble;
    logic             flush;
    logic [31:0]      busy;
    logic             state;
    logic [CNT_W-1:0] scnt;
    logic [CNT_W-1:0] fcnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   failures;

  hazard_scoreboard #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_long(id_long), .id_fence(id_fence),
    .done_valid(done_valid), .done_rd(done_rd), .ex_redirect(ex_redirect),
    .stall_if(stall_if), .bubble_idex(bubble_idex), .flush_ifid(flush_ifid),
    .busy(busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input string field, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s.%s actual=0x%0h required=0x%0h", name, field, act, req);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmp(e.name, "stall_if",    {31'd0, stall_if},    {31'd0, e.stall_if});
    cmp(e.name, "bubble_idex", {31'd0, bubble_idex}, {31'd0, e.bubble});
    cmp(e.name, "flush_ifid",  {31'd0, flush_ifid},  {31'd0, e.flush});
    cmp(e.name, "busy",        busy,                 e.busy);
    cmp(e.name, "state",       {31'd0, state},       {31'd0, e.state});
    cmp(e.name, "stall_cnt",   {16'd0, stall_cnt},   {16'd0, e.scnt});
    cmp(e.name, "flush_cnt",   {16'd0, flush_cnt},   {16'd0, e.fcnt});
  endtask

  // Monitor: inputs settle just after posedge, so the falling edge sees a stable cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      checkOutput(exp_q.pop_front());
    end
  end

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                        input logic rw, input logic lng, input logic fen);
    id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    id_rd = rd; id_regwrite = rw; id_long = lng; id_fence = fen;
  endtask

  task automatic set_misc(input logic dv, input logic [4:0] dr, input logic redir);
    done_valid = dv; done_rd = dr; ex_redirect = redir;
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_misc(0, 0, 0);
  endtask

  task automatic applyStimulus(input string name, input logic s, input logic b, input logic f,
                               input logic [31:0] bz, input logic st,
                               input logic [CNT_W-1:0] sc, input logic [CNT_W-1:0] fc);
    exp_t e;
    e.name = name; e.stall_if = s; e.bubble = b; e.flush = f;
    e.busy = bz; e.state = st; e.scnt = sc; e.fcnt = fc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    idle();
    @(posedge clk);
    #1;

    applyStimulus("reset_idle", 0, 0, 0, 32'h0, 0, 16'd0, 16'd0);
    set_misc(0, 0, 1);
    applyStimulus("reset_redirect", 0, 1, 1, 32'h0, 0, 16'd0, 16'd0);
    rst = 1'b0;

    // Load-use on x5
    idle(); set_id(1, 0, 0, 0, 0, 5, 1, 1, 0);
    applyStimulus("lu_issue_lw", 0, 0, 0, 32'h0, 0, 16'd0, 16'd0);
    set_id(1, 5, 1, 0, 0, 6, 1, 0, 0);
    applyStimulus("lu_stall1", 1, 1, 0, 32'h20, 0, 16'd0, 16'd0);
    applyStimulus("lu_stall2", 1, 1, 0, 32'h20, 0, 16'd1, 16'd0);
    set_misc(1, 5, 0);
    applyStimulus("lu_done", 0, 0, 0, 32'h20, 0, 16'd2, 16'd0);
    idle();
    applyStimulus("lu_after", 0, 0, 0, 32'h0, 0, 16'd2, 16'd0);

    // x0 is never tracked
    set_id(1, 0, 0, 0, 0, 0, 1, 1, 0);
    applyStimulus("x0_lw", 0, 0, 0, 32'h0, 0, 16'd2, 16'd0);
    set_id(1, 0, 1, 0, 1, 1, 1, 0, 0); set_misc(1, 0, 0);
    applyStimulus("x0_use", 0, 0, 0, 32'h0, 0, 16'd2, 16'd0);
    idle();
    applyStimulus("x0_after", 0, 0, 0, 32'h0, 0, 16'd2, 16'd0);

    // Redirect beats a pending dependency stall
    set_id(1, 0, 0, 0, 0, 4, 1, 1, 0);
    applyStimulus("rd_lw4", 0, 0, 0, 32'h0, 0, 16'd2, 16'd0);
    set_id(1, 0, 0, 4, 1, 8, 1, 1, 0); set_misc(0, 0, 1);
    applyStimulus("rd_redirect", 0, 1, 1, 32'h10, 0, 16'd2, 16'd0);
    set_misc(0, 0, 0);
    applyStimulus("rd_stall", 1, 1, 0, 32'h10, 0, 16'd2, 16'd1);
    idle(); set_misc(1, 4, 0);
    applyStimulus("rd_done4", 0, 0, 0, 32'h10, 0, 16'd3, 16'd1);
    idle();
    applyStimulus("rd_after", 0, 0, 0, 32'h0, 0, 16'd3, 16'd1);

    // Same-edge set and clear of x7
    set_id(1, 0, 0, 0, 0, 7, 1, 1, 0);
    applyStimulus("se_div7", 0, 0, 0, 32'h0, 0, 16'd3, 16'd1);
    set_misc(1, 7, 0);
    applyStimulus("se_set_clear", 0, 0, 0, 32'h80, 0, 16'd3, 16'd1);
    idle();
    applyStimulus("se_still_busy", 0, 0, 0, 32'h80, 0, 16'd3, 16'd1);
    set_misc(1, 7, 0);
    applyStimulus("se_done7", 0, 0, 0, 32'h80, 0, 16'd3, 16'd1);

    // Fence drain with x3 and x9 outstanding
    set_id(1, 0, 0, 0, 0, 3, 1, 1, 0); set_misc(0, 0, 0);
    applyStimulus("fd_lw3", 0, 0, 0, 32'h0, 0, 16'd3, 16'd1);
    set_id(1, 0, 0, 0, 0, 9, 1, 1, 0);
    applyStimulus("fd_lw9", 0, 0, 0, 32'h8, 0, 16'd3, 16'd1);
    set_id(1, 0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus("fd_fence", 1, 1, 0, 32'h208, 0, 16'd3, 16'd1);
    set_misc(1, 3, 0);
    applyStimulus("fd_done3", 1, 1, 0, 32'h208, 1, 16'd4, 16'd1);
    set_misc(1, 9, 0);
    applyStimulus("fd_done9", 0, 0, 0, 32'h200, 1, 16'd5, 16'd1);
    idle();
    applyStimulus("fd_run", 0, 0, 0, 32'h0, 0, 16'd5, 16'd1);

    // Redirect pulls the FSM out of DRAIN
    set_id(1, 0, 0, 0, 0, 2, 1, 1, 0);
    applyStimulus("fr_lw2", 0, 0, 0, 32'h0, 0, 16'd5, 16'd1);
    set_id(1, 0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus("fr_fence", 1, 1, 0, 32'h4, 0, 16'd5, 16'd1);
    set_misc(0, 0, 1);
    applyStimulus("fr_redirect", 0, 1, 1, 32'h4, 1, 16'd6, 16'd1);
    idle();
    applyStimulus("fr_run", 0, 0, 0, 32'h4, 0, 16'd6, 16'd2);

    // Saturate stall_cnt with a fence parked behind x2
    set_id(1, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
      @(posedge clk);
    end
    #1;
    applyStimulus("sat_hold", 1, 1, 0, 32'h4, 1, 16'hFFFF, 16'd2);
    applyStimulus("sat_hold2", 1, 1, 0, 32'h4, 1, 16'hFFFF, 16'd2);
    rst = 1'b1;
    applyStimulus("async_reset", 0, 0, 0, 32'h0, 0, 16'd0, 16'd0);
    rst = 1'b0;
    idle();
    applyStimulus("post_reset", 0, 0, 0, 32'h0, 0, 16'd0, 16'd0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      @(posedge clk);
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain_queue actual=%0d pending required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
